// File: rtl/saber_pkg.sv
// Shared encodings and length constants for the lightsaber controller and its datapath.
package saber_pkg;

  localparam int LEN_W = 9;

  // Blade length is carried as a total in hundredths of a metre.
  localparam logic [LEN_W-1:0] LEN_1M = 9'd100;
  localparam logic [LEN_W-1:0] LEN_2M = 9'd200;
  localparam logic [LEN_W-1:0] LEN_3M = 9'd300;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_IGNITE  = 3'd1,
    ST_ON      = 3'd2,
    ST_RETRACT = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    USE_IDLE  = 2'd0,
    USE_TRAIN = 2'd1,
    USE_DUEL  = 2'd2,
    USE_CUT   = 2'd3
  } use_e;

  typedef enum logic {
    MODE_RECHARGE  = 1'b0,
    MODE_DISCHARGE = 1'b1
  } mode_e;

  function automatic logic [LEN_W-1:0] target_len(input logic [1:0] metres,
                                                   input logic [5:0] hund);
    logic [6:0] hund_c;
    hund_c = (7'(hund) > 7'd99) ? 7'd99 : 7'(hund);
    return (9'(metres) * LEN_1M) + 9'(hund_c);
  endfunction

endpackage

// File: rtl/saber_len_split.sv
// Splits a total length in hundredths into whole metres and the hundredths remainder.
module saber_len_split
  import saber_pkg::*;
(
  input  logic [LEN_W-1:0] len,
  output logic [1:0]       metres,
  output logic [5:0]       hund
);

  // The hundredths output is 6 bits wide, so only the low 6 bits of the remainder survive.
  always_comb begin
    metres = 2'd0;
    hund   = 6'(len);
    if (len >= LEN_3M) begin
      metres = 2'd3;
      hund   = 6'(len - LEN_3M);
    end else if (len >= LEN_2M) begin
      metres = 2'd2;
      hund   = 6'(len - LEN_2M);
    end else if (len >= LEN_1M) begin
      metres = 2'd1;
      hund   = 6'(len - LEN_1M);
    end
  end

endmodule

// File: rtl/saber_sequencer.sv
// Blade ignition/retraction sequencer with power arbitration and exhausted-power lockout.
module saber_sequencer
  import saber_pkg::*;
#(
  parameter int RAMP_STEP  = 10,
  parameter int LOW_LVL    = 20,
  parameter int RESUME_LVL = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [1:0] tgt_in,
  input  logic [5:0] tgt_dec,
  input  logic [1:0] use_req,
  input  logic       mode_req,
  input  logic [7:0] power_lvl,
  input  logic       power_warn,
  output logic       saber_on,
  output logic [1:0] len_in,
  output logic [5:0] len_dec,
  output logic [1:0] use_out,
  output logic       mode_out,
  output logic       denied,
  output logic [2:0] state
);

  localparam logic [LEN_W-1:0] STEP    = 9'(RAMP_STEP);
  localparam logic [LEN_W:0]   STEP_W  = 10'(RAMP_STEP);
  localparam logic [7:0]       LOW_L   = 8'(LOW_LVL);
  localparam logic [7:0]       RESUME_L = 8'(RESUME_LVL);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             forced_q, forced_d;
  logic             btn_q;
  logic             saber_on_q, saber_on_d;
  logic [1:0]       use_q, use_d;
  logic             mode_q, mode_d;
  logic             denied_q, denied_d;
  logic [1:0]       len_in_q, len_in_d;
  logic [5:0]       len_dec_q, len_dec_d;

  logic             press;
  logic [LEN_W-1:0] tgt;
  logic [LEN_W:0]   len_up;
  logic [LEN_W-1:0] up_sat, dn_tgt, dn_zero;
  logic [1:0]       use_lim;

  assign press   = btn & ~btn_q;
  assign tgt     = target_len(tgt_in, tgt_dec);
  assign len_up  = {1'b0, len_q} + STEP_W;
  assign up_sat  = (len_up >= {1'b0, tgt}) ? tgt : len_up[LEN_W-1:0];
  // Compare in 10 bits so tgt + STEP cannot wrap near the 3.99 m ceiling.
  assign dn_tgt  = ({1'b0, len_q} <= ({1'b0, tgt} + STEP_W)) ? tgt : (len_q - STEP);
  assign dn_zero = (len_q <= STEP) ? '0 : (len_q - STEP);
  assign use_lim = (use_req > USE_TRAIN) ? USE_TRAIN : use_req;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    forced_d = forced_q;
    denied_d = 1'b0;
    case (state_q)
      ST_OFF: begin
        len_d = '0;
        if (press) begin
          if (power_lvl >= LOW_L) state_d = ST_IGNITE;
          else                    denied_d = 1'b1;
        end
      end
      ST_IGNITE: begin
        if (press) begin
          state_d = ST_RETRACT;
        end else begin
          len_d = up_sat;
          if (up_sat == tgt) state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (power_lvl == 8'd0) begin
          state_d  = ST_RETRACT;
          forced_d = 1'b1;
        end else if (press) begin
          state_d = ST_RETRACT;
        end else if (len_q < tgt) begin
          len_d = up_sat;
        end else begin
          len_d = dn_tgt;
        end
      end
      ST_RETRACT: begin
        len_d = dn_zero;
        if (dn_zero == '0) state_d = forced_q ? ST_LOCKOUT : ST_OFF;
      end
      ST_LOCKOUT: begin
        len_d = '0;
        if (power_lvl >= RESUME_L) begin
          state_d  = ST_OFF;
          forced_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_OFF;
        len_d    = '0;
        forced_d = 1'b0;
      end
    endcase
  end

  // Outputs are registered from the state being entered, so they line up with state.
  always_comb begin
    saber_on_d = 1'b0;
    use_d      = USE_IDLE;
    mode_d     = MODE_RECHARGE;
    case (state_d)
      ST_IGNITE, ST_ON: begin
        saber_on_d = 1'b1;
        mode_d     = mode_req;
        use_d      = power_warn ? use_lim : use_req;
      end
      ST_RETRACT: begin
        saber_on_d = 1'b1;
        mode_d     = mode_req;
        use_d      = use_lim;
      end
      default: ;
    endcase
  end

  saber_len_split u_len_split (
    .len    (len_d),
    .metres (len_in_d),
    .hund   (len_dec_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_OFF;
      len_q      <= '0;
      forced_q   <= 1'b0;
      btn_q      <= 1'b0;
      saber_on_q <= 1'b0;
      use_q      <= USE_IDLE;
      mode_q     <= MODE_RECHARGE;
      denied_q   <= 1'b0;
      len_in_q   <= 2'd0;
      len_dec_q  <= 6'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      forced_q   <= forced_d;
      btn_q      <= btn;
      saber_on_q <= saber_on_d;
      use_q      <= use_d;
      mode_q     <= mode_d;
      denied_q   <= denied_d;
      len_in_q   <= len_in_d;
      len_dec_q  <= len_dec_d;
    end
  end

  assign saber_on = saber_on_q;
  assign len_in   = len_in_q;
  assign len_dec  = len_dec_q;
  assign use_out  = use_q;
  assign mode_out = mode_q;
  assign denied   = denied_q;
  assign state    = state_q;

endmodule

// File: tb/tb_saber_sequencer.sv
// Scoreboard bench for saber_sequencer: directed stimulus pushes expected outputs, a monitor compares.
module tb_saber_sequencer;
  import saber_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic [1:0] tgt_in = 2'd0;
  logic [5:0] tgt_dec = 6'd0;
  logic [1:0] use_req = 2'd2;
  logic       mode_req = 1'b1;
  logic [7:0] power_lvl = 8'd200;
  logic       power_warn = 1'b0;

  logic       saber_on;
  logic [1:0] len_in;
  logic [5:0] len_dec;
  logic [1:0] use_out;
  logic       mode_out;
  logic       denied;
  logic [2:0] state;

  saber_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .tgt_in     (tgt_in),
    .tgt_dec    (tgt_dec),
    .use_req    (use_req),
    .mode_req   (mode_req),
    .power_lvl  (power_lvl),
    .power_warn (power_warn),
    .saber_on   (saber_on),
    .len_in     (len_in),
    .len_dec    (len_dec),
    .use_out    (use_out),
    .mode_out   (mode_out),
    .denied     (denied),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    st;
    int    len;
    bit    on;
    int    use_v;
    bit    mode;
    bit    den;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input string nm, input int st, input int len, input bit on,
                              input int u, input bit m, input bit d);
    exp_t e;
    e.name = nm; e.st = st; e.len = len; e.on = on; e.use_v = u; e.mode = m; e.den = d;
    return e;
  endfunction

  // len_dec is a 6-bit port, so the expected hundredths are taken modulo 64.
  task automatic check(input exp_t e);
    int em, eh;
    em = e.len / 100;
    eh = (e.len % 100) & 63;
    checks++;
    if (int'(state) != e.st || int'(len_in) != em || int'(len_dec) != eh || saber_on != e.on ||
        int'(use_out) != e.use_v || mode_out != e.mode || denied != e.den) begin
      errors++;
      $display("FAIL %s: got st=%0d len=%0d.%0d on=%0d use=%0d mode=%0d den=%0d, want st=%0d len=%0d.%0d on=%0d use=%0d mode=%0d den=%0d",
               e.name, state, len_in, len_dec, saber_on, use_out, mode_out, denied,
               e.st, em, eh, e.on, e.use_v, e.mode, e.den);
    end else begin
      $display("ok   %s: st=%0d len=%0d.%0d on=%0d use=%0d mode=%0d den=%0d",
               e.name, state, len_in, len_dec, saber_on, use_out, mode_out, denied);
    end
  endtask

  always @(negedge clk) begin
    if (rst && q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check(e);
    end
  end

  // Inputs are already set; queue what the outputs must be after the next rising edge.
  task automatic tick(input string nm, input int st, input int len, input bit on,
                      input int u, input bit m, input bit d);
    q.push_back(mk(nm, st, len, on, u, m, d));
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int l;
    #2;
    check(mk("reset", 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;

    // Ignite to 1.50
    tgt_in = 2'd1; tgt_dec = 6'd50;
    tick("idle", 0, 0, 0, 0, 0, 0);
    btn = 1'b1;
    tick("press", 1, 0, 1, 2, 1, 0);
    btn = 1'b0;
    for (int k = 1; k <= 15; k++)
      tick($sformatf("ign_%0d", k), (k == 15) ? 2 : 1, 10 * k, 1, 2, 1, 0);
    tick("on_hold", 2, 150, 1, 2, 1, 0);

    // Grow to 2.33, then retract
    tgt_in = 2'd2; tgt_dec = 6'd33;
    for (int k = 1; k <= 9; k++)
      tick($sformatf("grow_%0d", k), 2, (k == 9) ? 233 : 150 + 10 * k, 1, 2, 1, 0);
    tick("grow_hold", 2, 233, 1, 2, 1, 0);
    btn = 1'b1;
    tick("ret_press", 3, 233, 1, 1, 1, 0);
    btn = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      l = 233 - 10 * k;
      if (l < 0) l = 0;
      tick($sformatf("ret_%0d", k), (k == 24) ? 0 : 3, l, k < 24, (k < 24) ? 1 : 0, k < 24, 0);
    end

    // Ignition refused below LOW_LVL
    power_lvl = 8'd19;
    btn = 1'b1;
    tick("deny19", 0, 0, 0, 0, 0, 1);
    btn = 1'b0;
    tick("deny19_end", 0, 0, 0, 0, 0, 0);
    power_lvl = 8'd10;
    btn = 1'b1;
    tick("deny10", 0, 0, 0, 0, 0, 1);
    btn = 1'b0;
    tick("deny10_end", 0, 0, 0, 0, 0, 0);

    // Warning limits usage; exhausted power forces retract and lockout
    power_lvl = 8'd200; use_req = 2'd3;
    tgt_in = 2'd0; tgt_dec = 6'd30;
    btn = 1'b1;
    tick("p4_press", 1, 0, 1, 3, 1, 0);
    btn = 1'b0;
    for (int k = 1; k <= 3; k++)
      tick($sformatf("p4_ign_%0d", k), (k == 3) ? 2 : 1, 10 * k, 1, 3, 1, 0);
    power_warn = 1'b1;
    tick("warn", 2, 30, 1, 1, 1, 0);
    power_lvl = 8'd0;
    tick("forced", 3, 30, 1, 1, 1, 0);
    tick("forced_1", 3, 20, 1, 1, 1, 0);
    tick("forced_2", 3, 10, 1, 1, 1, 0);
    tick("lockout", 4, 0, 0, 0, 0, 0);
    btn = 1'b1;
    tick("lock_press", 4, 0, 0, 0, 0, 0);
    btn = 1'b0;
    power_lvl = 8'd63;
    tick("lock_63", 4, 0, 0, 0, 0, 0);
    power_lvl = 8'd64;
    tick("resume_64", 0, 0, 0, 0, 0, 0);
    power_warn = 1'b0; use_req = 2'd2;

    // Abort during ignition at exactly LOW_LVL; second press in retract ignored
    power_lvl = 8'd20; mode_req = 1'b0;
    tgt_in = 2'd1; tgt_dec = 6'd0;
    btn = 1'b1;
    tick("p5_press", 1, 0, 1, 2, 0, 0);
    btn = 1'b0;
    for (int k = 1; k <= 4; k++)
      tick($sformatf("p5_ign_%0d", k), 1, 10 * k, 1, 2, 0, 0);
    btn = 1'b1;
    tick("ign_abort", 3, 40, 1, 1, 0, 0);
    btn = 1'b0;
    tick("abort_1", 3, 30, 1, 1, 0, 0);
    btn = 1'b1;
    tick("ret_ignore", 3, 20, 1, 1, 0, 0);
    btn = 1'b0;
    tick("abort_3", 3, 10, 1, 1, 0, 0);
    tick("abort_off", 0, 0, 0, 0, 0, 0);
    power_lvl = 8'd200; mode_req = 1'b1;

    // Zero target
    tgt_in = 2'd0; tgt_dec = 6'd0;
    btn = 1'b1;
    tick("zero_press", 1, 0, 1, 2, 1, 0);
    btn = 1'b0;
    tick("zero_on", 2, 0, 1, 2, 1, 0);
    btn = 1'b1;
    tick("zero_ret", 3, 0, 1, 1, 1, 0);
    btn = 1'b0;
    tick("zero_off", 0, 0, 0, 0, 0, 0);

    // Held button gives one press; ramp to 3.63 then step down to 3.43
    tgt_in = 2'd3; tgt_dec = 6'd63;
    for (int k = 1; k <= 38; k++) begin
      btn = (k <= 20);
      l = 10 * (k - 1);
      if (l > 363) l = 363;
      tick($sformatf("hold_%0d", k), (k == 38) ? 2 : 1, l, 1, 2, 1, 0);
    end
    btn = 1'b0;
    tgt_dec = 6'd43;
    tick("down_1", 2, 353, 1, 2, 1, 0);
    tick("down_2", 2, 343, 1, 2, 1, 0);
    tick("down_hold", 2, 343, 1, 2, 1, 0);

    // Asynchronous reset between edges, with btn held through it
    btn = 1'b1;
    #2 rst = 1'b0;
    #1 check(mk("rst_async_on", 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1 check(mk("rst_hold", 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    tgt_in = 2'd1; tgt_dec = 6'd0;
    tick("rst_btn_edge", 1, 0, 1, 2, 1, 0);
    btn = 1'b0;
    tick("mid_ign_1", 1, 10, 1, 2, 1, 0);
    tick("mid_ign_2", 1, 20, 1, 2, 1, 0);
    #2 rst = 1'b0;
    #1 check(mk("rst_mid_ign", 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1 rst = 1'b1;
    tick("after_rst", 0, 0, 0, 0, 0, 0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
